ccd_trig_monitor: RTL and testbench

Receive-side checker for the CCD exposure trigger used in 2D scans. It samples the `ccd` trigger line as an asynchronous input and emits one pulse per detected trigger. It tracks the X/Y scan position, checks the trigger period against `cycles_per_points`, and flags period errors and missing-trigger timeouts. It sits beside the acquisition path and gives the capture and control logic line and frame boundaries.

---
 rtl/ccd_trig_monitor.sv | 181 ++++++++++++++++++
 tb/tb_ccd_trig_monitor.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/ccd_trig_monitor.sv
// Receive-side checker for the CCD exposure trigger: synchronizes the trigger line, tracks X/Y
// scan position, measures the trigger period and flags period errors and missing triggers.
module ccd_trig_monitor #(
  parameter int unsigned PERIOD_TOL = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ccd_in,
  input  logic        arm,
  input  logic        KILL_PROCESS,
  input  logic [15:0] xdata_points_number,
  input  logic [15:0] ydata_points_number,
  input  logic [15:0] cycles_per_points,
  input  logic [31:0] timeout_cycles,
  output logic        trig_pulse,
  output logic [15:0] x_index,
  output logic [15:0] y_index,
  output logic        line_done,
  output logic        frame_done,
  output logic        busy,
  output logic [31:0] last_period,
  output logic        period_err,
  output logic        timeout_err,
  output logic        aborted
);

  typedef enum logic [1:0] {StIdle, StArmed, StRun} state_e;

  state_e      state_q, state_d;
  logic        s1_q, s2_q, s3_q;
  logic [31:0] cnt_q, cnt_d;
  logic [15:0] pts_q, pts_d;
  logic [15:0] x_index_q, x_index_d;
  logic [15:0] y_index_q, y_index_d;
  logic        trig_q, trig_d;
  logic        line_q, line_d;
  logic        frame_q, frame_d;
  logic        abort_q, abort_d;
  logic        busy_q, busy_d;
  logic [31:0] last_period_q, last_period_d;
  logic        period_err_q, period_err_d;
  logic        timeout_err_q, timeout_err_d;

  logic        edge_det;
  logic [15:0] xpts_eff, ypts_eff;
  logic        line_end, frame_end;
  logic [32:0] meas_33, exp_33, diff_33;
  logic        period_bad;

  assign edge_det = s2_q & ~s3_q;
  assign xpts_eff = (xdata_points_number == 16'd0) ? 16'd1 : xdata_points_number;
  assign ypts_eff = (ydata_points_number == 16'd0) ? 16'd1 : ydata_points_number;

  // 17-bit compares so a full 16-bit count cannot wrap past the limit
  assign line_end  = ({1'b0, pts_q} + 17'd1) >= {1'b0, xpts_eff};
  assign frame_end = ({1'b0, y_index_q} + 17'd1) >= {1'b0, ypts_eff};

  // The period checked is the one being latched into last_period on this edge
  assign meas_33    = {1'b0, cnt_q};
  assign exp_33     = {17'd0, cycles_per_points} + 33'd1;
  assign diff_33    = (meas_33 >= exp_33) ? (meas_33 - exp_33) : (exp_33 - meas_33);
  assign period_bad = diff_33 > 33'(PERIOD_TOL);

  always_comb begin
    state_d       = state_q;
    trig_d        = 1'b0;
    line_d        = 1'b0;
    frame_d       = 1'b0;
    abort_d       = 1'b0;
    pts_d         = pts_q;
    x_index_d     = x_index_q;
    y_index_d     = line_q ? (y_index_q + 16'd1) : y_index_q;
    last_period_d = last_period_q;
    period_err_d  = period_err_q;
    timeout_err_d = timeout_err_q;
    if (edge_det) begin
      cnt_d = 32'd1;
    end else if (cnt_q == 32'hFFFF_FFFF) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + 32'd1;
    end

    unique case (state_q)
      StIdle: begin
        if (arm) begin
          state_d       = StArmed;
          period_err_d  = 1'b0;
          timeout_err_d = 1'b0;
          x_index_d     = 16'd0;
          y_index_d     = 16'd0;
          pts_d         = 16'd0;
          cnt_d         = 32'd0;
        end
      end
      StArmed, StRun: begin
        if (KILL_PROCESS) begin
          state_d = StIdle;
          abort_d = 1'b1;
        end else if (edge_det) begin
          state_d   = StRun;
          trig_d    = 1'b1;
          x_index_d = pts_q;
          if (line_end) begin
            line_d = 1'b1;
            pts_d  = 16'd0;
            if (frame_end) begin
              frame_d = 1'b1;
              state_d = StIdle;
            end
          end else begin
            pts_d = pts_q + 16'd1;
          end
          // The frame's first edge has no predecessor; a line's first edge follows flyback
          if (state_q == StRun) begin
            last_period_d = cnt_q;
            if ((pts_q != 16'd0) && period_bad) begin
              period_err_d = 1'b1;
            end
          end
        end else if ((timeout_cycles != 32'd0) && (cnt_q >= timeout_cycles)) begin
          timeout_err_d = 1'b1;
          state_d       = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      s1_q          <= 1'b0;
      s2_q          <= 1'b0;
      s3_q          <= 1'b0;
      cnt_q         <= 32'd0;
      pts_q         <= 16'd0;
      x_index_q     <= 16'd0;
      y_index_q     <= 16'd0;
      trig_q        <= 1'b0;
      line_q        <= 1'b0;
      frame_q       <= 1'b0;
      abort_q       <= 1'b0;
      busy_q        <= 1'b0;
      last_period_q <= 32'd0;
      period_err_q  <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      s1_q          <= ccd_in;
      s2_q          <= s1_q;
      s3_q          <= s2_q;
      cnt_q         <= cnt_d;
      pts_q         <= pts_d;
      x_index_q     <= x_index_d;
      y_index_q     <= y_index_d;
      trig_q        <= trig_d;
      line_q        <= line_d;
      frame_q       <= frame_d;
      abort_q       <= abort_d;
      busy_q        <= busy_d;
      last_period_q <= last_period_d;
      period_err_q  <= period_err_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign trig_pulse  = trig_q;
  assign x_index     = x_index_q;
  assign y_index     = y_index_q;
  assign line_done   = line_q;
  assign frame_done  = frame_q;
  assign busy        = busy_q;
  assign last_period = last_period_q;
  assign period_err  = period_err_q;
  assign timeout_err = timeout_err_q;
  assign aborted     = abort_q;

endmodule

// File: tb/tb_ccd_trig_monitor.sv
// Directed bench for ccd_trig_monitor: frames, period errors, flyback gaps, timeout, kill, reset.
module tb_ccd_trig_monitor;

  logic        clk = 1'b0;
  logic        rst, ccd_in, arm, KILL_PROCESS;
  logic [15:0] xpts, ypts, cpp;
  logic [31:0] tmo;
  logic        trig_pulse, line_done, frame_done, busy, period_err, timeout_err, aborted;
  logic [15:0] x_index, y_index;
  logic [31:0] last_period;

  int n_checks = 0;
  int n_fail   = 0;

  // Pulse tallies and first-rise capture of period_err, sampled mid-cycle
  int          n_trig = 0, n_line_ok = 0, n_frame = 0, n_abort = 0, perr_rise = 0;
  logic        perr_prev = 1'b0;
  logic        perr_trig;
  logic [31:0] perr_lp;
  logic [15:0] perr_x;
  int          b_trig, b_line, b_frame, b_abort, b_rise;

  always #5 clk = ~clk;

  ccd_trig_monitor #(.PERIOD_TOL(1)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .ccd_in              (ccd_in),
    .arm                 (arm),
    .KILL_PROCESS        (KILL_PROCESS),
    .xdata_points_number (xpts),
    .ydata_points_number (ypts),
    .cycles_per_points   (cpp),
    .timeout_cycles      (tmo),
    .trig_pulse          (trig_pulse),
    .x_index             (x_index),
    .y_index             (y_index),
    .line_done           (line_done),
    .frame_done          (frame_done),
    .busy                (busy),
    .last_period         (last_period),
    .period_err          (period_err),
    .timeout_err         (timeout_err),
    .aborted             (aborted)
  );

  always @(negedge clk) begin
    if (trig_pulse === 1'b1) n_trig++;
    if (line_done === 1'b1 && x_index === xpts - 16'd1) n_line_ok++;
    if (frame_done === 1'b1) n_frame++;
    if (aborted === 1'b1) n_abort++;
    if (period_err === 1'b1 && perr_prev !== 1'b1) begin
      perr_rise++;
      perr_trig = trig_pulse;
      perr_lp   = last_period;
      perr_x    = x_index;
    end
    perr_prev = period_err;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d (0x%0h), expected %0d", tag, obs, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One trigger: high 3 cycles, next rise 'gap' cycles after this one
  task automatic trig(input int gap);
    ccd_in = 1'b1;
    repeat (3) step();
    ccd_in = 1'b0;
    repeat (gap - 3) step();
  endtask

  task automatic do_arm();
    arm = 1'b1;
    step();
    arm = 1'b0;
  endtask

  task automatic snap();
    b_trig  = n_trig;
    b_line  = n_line_ok;
    b_frame = n_frame;
    b_abort = n_abort;
    b_rise  = perr_rise;
  endtask

  task automatic check_all_zero(input string tag);
    logic any;
    any = |{trig_pulse, x_index, y_index, line_done, frame_done, busy, last_period,
            period_err, timeout_err, aborted};
    check(tag, 32'(any), 32'd0);
  endtask

  initial begin
    rst = 1'b1; ccd_in = 1'b0; arm = 1'b0; KILL_PROCESS = 1'b0;
    xpts = 16'd4; ypts = 16'd2; cpp = 16'd9; tmo = 32'd0;
    repeat (3) step();
    rst = 1'b0;
    check_all_zero("reset_outputs");
    check("reset_busy", 32'(busy), 32'd0);

    // Basic frame: 4x2 at an ideal 10-cycle period
    snap();
    do_arm();
    check("basic_busy_rise", 32'(busy), 32'd1);
    repeat (8) trig(10);
    repeat (5) step();
    check("basic_trig_count", 32'(n_trig - b_trig), 32'd8);
    check("basic_line_done_x3", 32'(n_line_ok - b_line), 32'd2);
    check("basic_frame_done", 32'(n_frame - b_frame), 32'd1);
    check("basic_last_period", last_period, 32'd10);
    check("basic_period_err", 32'(period_err), 32'd0);
    check("basic_timeout_err", 32'(timeout_err), 32'd0);
    check("basic_busy_fall", 32'(busy), 32'd0);

    // Period error: an 11 inside tolerance, then a 13 mid-line
    snap();
    do_arm();
    trig(10); trig(11); trig(10); trig(10);
    check("perr_11_tolerated", 32'(period_err), 32'd0);
    trig(10); trig(13); trig(10); trig(10);
    repeat (5) step();
    check("perr_rise_once", 32'(perr_rise - b_rise), 32'd1);
    check("perr_with_trig", 32'(perr_trig), 32'd1);
    check("perr_period13", perr_lp, 32'd13);
    check("perr_x_index", 32'(perr_x), 32'd2);
    check("perr_sticky", 32'(period_err), 32'd1);
    check("perr_frame_done", 32'(n_frame - b_frame), 32'd1);

    // Flyback gap of 100 cycles between lines is exempt
    snap();
    do_arm();
    check("gap_arm_clears_err", 32'(period_err), 32'd0);
    check("gap_y0", 32'(y_index), 32'd0);
    trig(10); trig(10); trig(10); trig(100);
    check("gap_y1", 32'(y_index), 32'd1);
    trig(10);
    check("gap_last_period100", last_period, 32'd100);
    check("gap_no_err_first", 32'(period_err), 32'd0);
    repeat (3) trig(10);
    repeat (5) step();
    check("gap_no_err_frame", 32'(period_err), 32'd0);
    check("gap_frame_done", 32'(n_frame - b_frame), 32'd1);
    check("gap_last_period10", last_period, 32'd10);

    // Timeout: triggers stop after 3 edges with a 50-cycle limit
    snap();
    tmo = 32'd50;
    do_arm();
    repeat (3) trig(10);
    check("tmo_busy_before", 32'(busy), 32'd1);
    check("tmo_err_before", 32'(timeout_err), 32'd0);
    repeat (60) step();
    check("tmo_err", 32'(timeout_err), 32'd1);
    check("tmo_busy_low", 32'(busy), 32'd0);
    check("tmo_no_frame", 32'(n_frame - b_frame), 32'd0);
    check("tmo_trig_count", 32'(n_trig - b_trig), 32'd3);

    // Timeout disabled: stays in RUN; a 13-cycle period sets period_err
    tmo = 32'd0;
    do_arm();
    check("notmo_arm_clears", 32'(timeout_err), 32'd0);
    trig(10); trig(13); trig(10);
    repeat (200) step();
    check("notmo_busy", 32'(busy), 32'd1);
    check("notmo_no_err", 32'(timeout_err), 32'd0);
    check("notmo_perr", 32'(period_err), 32'd1);
    check("notmo_x2", 32'(x_index), 32'd2);

    // Kill in the same cycle an edge is detected
    snap();
    ccd_in = 1'b1;
    step(); step();
    KILL_PROCESS = 1'b1;
    step();
    KILL_PROCESS = 1'b0;
    check("kill_no_trig", 32'(trig_pulse), 32'd0);
    check("kill_aborted", 32'(aborted), 32'd1);
    check("kill_busy_low", 32'(busy), 32'd0);
    step(); step();
    ccd_in = 1'b0;
    repeat (5) step();
    check("kill_one_abort", 32'(n_abort - b_abort), 32'd1);
    check("kill_trig_count", 32'(n_trig - b_trig), 32'd0);
    check("kill_x_hold", 32'(x_index), 32'd2);
    check("kill_perr_hold", 32'(period_err), 32'd1);
    do_arm();
    check("rearm_busy", 32'(busy), 32'd1);
    check("rearm_perr_clear", 32'(period_err), 32'd0);
    check("rearm_x0", 32'(x_index), 32'd0);

    // Reset mid-frame, then edges ignored until the next arm
    trig(10); trig(10);
    check("rst_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_all_zero("rst_midframe_zero");
    snap();
    trig(10); trig(10);
    repeat (5) step();
    check("rst_edges_ignored", 32'(n_trig - b_trig), 32'd0);
    check("rst_busy_low", 32'(busy), 32'd0);
    do_arm();
    repeat (8) trig(10);
    repeat (5) step();
    check("rst_rearm_trig", 32'(n_trig - b_trig), 32'd8);
    check("rst_rearm_frame", 32'(n_frame - b_frame), 32'd1);
    check("rst_rearm_perr", 32'(period_err), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
